// File: rtl/cpu_pkg.sv
// Shared write-back types: register geometry, requester ids, buffered entry with arrival stamp.
package cpu_pkg;

   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 4;
   localparam int NUM_REGS = 16;
   localparam int STAMP_W  = 3;

   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_LD  = 1'b1
   } req_e;

   typedef struct packed {
      logic [ADDR_W-1:0]  add;
      logic [DATA_W-1:0]  data;
      logic [STAMP_W-1:0] stamp;
   } wb_entry_t;

   // True when stamp b was issued before stamp a; at most 4 live entries keeps the window unambiguous.
   function automatic logic is_older(input logic [STAMP_W-1:0] a, input logic [STAMP_W-1:0] b);
      logic [STAMP_W-1:0] diff;
      diff = a - b;
      return (diff >= 3'd1) && (diff <= 3'd3);
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small write-back entry buffer, one per requester; head is visible the cycle after the push.
// full/empty come from registered occupancy only, so a pop never frees a slot in the same cycle.
module wb_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      push,
   input  wb_entry_t din,
   input  logic      pop,
   output wb_entry_t head,
   output logic      full,
   output logic      empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   wb_entry_t       mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Merges ALU and load results onto the single register-file write port, keeps a pending-write scoreboard.
// Accept-to-write latency 2 edges; each requester backpressured by its own 2-entry buffer being full.
module regfile_wb_scheduler
   import cpu_pkg::wb_entry_t;
   import cpu_pkg::req_e;
   import cpu_pkg::REQ_ALU;
   import cpu_pkg::REQ_LD;
   import cpu_pkg::NUM_REGS;
   import cpu_pkg::STAMP_W;
   import cpu_pkg::is_older;
#(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 4,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_alu_valid,
   output logic              o_alu_ready,
   input  logic [ADDR_W-1:0] i_alu_add,
   input  logic [DATA_W-1:0] i_alu_data,
   input  logic              i_ld_valid,
   output logic              o_ld_ready,
   input  logic [ADDR_W-1:0] i_ld_add,
   input  logic [DATA_W-1:0] i_ld_data,
   input  logic              i_reserve_en,
   input  logic [ADDR_W-1:0] i_reserve_add,
   input  logic [ADDR_W-1:0] i_read_add1,
   input  logic [ADDR_W-1:0] i_read_add2,
   output logic              o_stall,
   output logic              o_write_en,
   output logic [ADDR_W-1:0] o_write_add,
   output logic [DATA_W-1:0] o_write_data,
   output logic              o_forward,
   output logic [ADDR_W-1:0] o_forward_add,
   output logic              o_sb_overflow
);

   wb_entry_t          alu_din, ld_din, alu_head, ld_head;
   logic               alu_full, alu_empty, ld_full, ld_empty;
   logic               alu_push, ld_push, alu_pop, ld_pop;
   logic [STAMP_W-1:0] stamp_cnt;
   req_e               last_grant;
   logic               grant_any, grant_ld;
   logic [ADDR_W-1:0]  grant_add;
   logic [DATA_W-1:0]  grant_data;
   logic [1:0]         sb_cnt [NUM_REGS];
   logic [1:0]         sb_nxt [NUM_REGS];
   logic [NUM_REGS-1:0] inc_vec, dec_vec;
   logic               ovf_set;

   assign o_alu_ready = reset && !alu_full;
   assign o_ld_ready  = reset && !ld_full;
   assign alu_push    = i_alu_valid && o_alu_ready;
   assign ld_push     = i_ld_valid && o_ld_ready;

   // On a simultaneous accept the load entry takes the older stamp.
   assign ld_din  = '{add: i_ld_add, data: i_ld_data, stamp: stamp_cnt};
   assign alu_din = '{add: i_alu_add, data: i_alu_data,
                      stamp: ld_push ? stamp_cnt + 3'd1 : stamp_cnt};

   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
      .clk(clk), .reset(reset), .push(alu_push), .din(alu_din), .pop(alu_pop),
      .head(alu_head), .full(alu_full), .empty(alu_empty)
   );

   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_ld_fifo (
      .clk(clk), .reset(reset), .push(ld_push), .din(ld_din), .pop(ld_pop),
      .head(ld_head), .full(ld_full), .empty(ld_empty)
   );

   always_comb begin
      grant_any = !alu_empty || !ld_empty;
      grant_ld  = 1'b0;
      if (!alu_empty && !ld_empty) begin
         if (alu_head.add == ld_head.add)
            grant_ld = is_older(alu_head.stamp, ld_head.stamp);
         else
            grant_ld = (last_grant == REQ_ALU);
      end else begin
         grant_ld = !ld_empty;
      end
   end

   assign alu_pop    = grant_any && !grant_ld;
   assign ld_pop     = grant_any && grant_ld;
   assign grant_add  = grant_ld ? ld_head.add  : alu_head.add;
   assign grant_data = grant_ld ? ld_head.data : alu_head.data;

   assign inc_vec = i_reserve_en ? (NUM_REGS'(1) << i_reserve_add) : '0;
   assign dec_vec = grant_any    ? (NUM_REGS'(1) << grant_add)     : '0;

   // Reserve and grant on the same register cancel; saturated reserve flags overflow instead.
   always_comb begin
      ovf_set = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
         sb_nxt[r] = sb_cnt[r];
         if (inc_vec[r] && !dec_vec[r]) begin
            if (sb_cnt[r] == 2'd3) ovf_set   = 1'b1;
            else                   sb_nxt[r] = sb_cnt[r] + 2'd1;
         end else if (dec_vec[r] && !inc_vec[r] && (sb_cnt[r] != 2'd0)) begin
            sb_nxt[r] = sb_cnt[r] - 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stamp_cnt     <= '0;
         last_grant    <= REQ_ALU;
         o_write_en    <= 1'b0;
         o_write_add   <= '0;
         o_write_data  <= '0;
         o_forward     <= 1'b0;
         o_forward_add <= '0;
         o_sb_overflow <= 1'b0;
         for (int r = 0; r < NUM_REGS; r++) sb_cnt[r] <= 2'd0;
      end else begin
         stamp_cnt  <= stamp_cnt + STAMP_W'(alu_push) + STAMP_W'(ld_push);
         o_write_en <= grant_any;
         o_forward  <= grant_any;
         if (grant_any) begin
            last_grant    <= grant_ld ? REQ_LD : REQ_ALU;
            o_write_add   <= grant_add;
            o_write_data  <= grant_data;
            o_forward_add <= grant_add;
         end
         if (ovf_set) o_sb_overflow <= 1'b1;
         for (int r = 0; r < NUM_REGS; r++) sb_cnt[r] <= sb_nxt[r];
      end
   end

   assign o_stall = reset && ((sb_cnt[i_read_add1] != 2'd0) || (sb_cnt[i_read_add2] != 2'd0));

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Randomized bench for regfile_wb_scheduler: queue-level reference model feeds an expected-write scoreboard.
module tb_regfile_wb_scheduler;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        i_alu_valid = 1'b0, i_ld_valid = 1'b0, i_reserve_en = 1'b0;
   logic [3:0]  i_alu_add = '0, i_ld_add = '0, i_reserve_add = '0, i_read_add1 = '0, i_read_add2 = '0;
   logic [15:0] i_alu_data = '0, i_ld_data = '0;
   logic        o_alu_ready, o_ld_ready, o_stall, o_write_en, o_forward, o_sb_overflow;
   logic [3:0]  o_write_add, o_forward_add;
   logic [15:0] o_write_data;

   regfile_wb_scheduler #(.DATA_W(16), .ADDR_W(4), .FIFO_DEPTH(2)) dut (
      .clk(clk), .reset(reset),
      .i_alu_valid(i_alu_valid), .o_alu_ready(o_alu_ready), .i_alu_add(i_alu_add), .i_alu_data(i_alu_data),
      .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready), .i_ld_add(i_ld_add), .i_ld_data(i_ld_data),
      .i_reserve_en(i_reserve_en), .i_reserve_add(i_reserve_add),
      .i_read_add1(i_read_add1), .i_read_add2(i_read_add2), .o_stall(o_stall),
      .o_write_en(o_write_en), .o_write_add(o_write_add), .o_write_data(o_write_data),
      .o_forward(o_forward), .o_forward_add(o_forward_add), .o_sb_overflow(o_sb_overflow)
   );

   always #5 clk = ~clk;

   typedef struct { int add; int data; int seq; } ment_t;
   typedef struct { int add; int data; } wexp_t;

   ment_t qa[$], ql[$];
   wexp_t exp_q[$];
   wexp_t mon_e;
   int    sb[16];
   bit    ovf;
   bit    last_ld;
   int    seq_ctr;
   bit    mon_on = 1'b0;
   int    n_vec = 0, n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      qa.delete(); ql.delete(); exp_q.delete();
      for (int r = 0; r < 16; r++) sb[r] = 0;
      ovf = 0; last_ld = 0; seq_ctr = 0;
   endtask

   // One clock of the abstract behaviour: arbitrate on old heads, then enqueue, then scoreboard.
   task automatic model_step();
      bit a_acc, l_acc, g, g_ld;
      int gadd;
      ment_t m;
      a_acc = i_alu_valid && (qa.size() < 2);
      l_acc = i_ld_valid && (ql.size() < 2);
      g = (qa.size() != 0) || (ql.size() != 0);
      g_ld = 0;
      gadd = 0;
      if (qa.size() != 0 && ql.size() != 0) begin
         if (qa[0].add == ql[0].add) g_ld = ql[0].seq < qa[0].seq;
         else                        g_ld = !last_ld;
      end else begin
         g_ld = (ql.size() != 0);
      end
      if (g) begin
         m = g_ld ? ql.pop_front() : qa.pop_front();
         exp_q.push_back('{add: m.add, data: m.data});
         gadd = m.add;
         last_ld = g_ld;
      end
      if (l_acc) begin ql.push_back('{add: int'(i_ld_add), data: int'(i_ld_data), seq: seq_ctr}); seq_ctr++; end
      if (a_acc) begin qa.push_back('{add: int'(i_alu_add), data: int'(i_alu_data), seq: seq_ctr}); seq_ctr++; end
      if (i_reserve_en && g && int'(i_reserve_add) == gadd) begin
         // reserve and release of the same register cancel
      end else begin
         if (i_reserve_en) begin
            if (sb[i_reserve_add] == 3) ovf = 1;
            else sb[i_reserve_add]++;
         end
         if (g && sb[gadd] > 0) sb[gadd]--;
      end
   endtask

   task automatic cyc(input bit av, input int aa, input int ad, input bit lv, input int la, input int ld,
                      input bit re, input int ra, input int r1, input int r2);
      @(negedge clk);
      chk("alu_ready", 32'(o_alu_ready), 32'(qa.size() < 2));
      chk("ld_ready", 32'(o_ld_ready), 32'(ql.size() < 2));
      chk("sb_overflow", 32'(o_sb_overflow), 32'(ovf));
      i_alu_valid = av; i_alu_add = 4'(aa); i_alu_data = 16'(ad);
      i_ld_valid = lv;  i_ld_add = 4'(la);  i_ld_data = 16'(ld);
      i_reserve_en = re; i_reserve_add = 4'(ra);
      i_read_add1 = 4'(r1); i_read_add2 = 4'(r2);
      #1;
      chk("stall", 32'(o_stall), 32'((sb[r1] != 0) || (sb[r2] != 0)));
      @(posedge clk);
      model_step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_write_en"}, 32'(o_write_en), 0);
      chk({tag, "_write_add"}, 32'(o_write_add), 0);
      chk({tag, "_write_data"}, 32'(o_write_data), 0);
      chk({tag, "_forward"}, 32'(o_forward), 0);
      chk({tag, "_forward_add"}, 32'(o_forward_add), 0);
      chk({tag, "_alu_ready"}, 32'(o_alu_ready), 0);
      chk({tag, "_ld_ready"}, 32'(o_ld_ready), 0);
      chk({tag, "_stall"}, 32'(o_stall), 0);
      chk({tag, "_overflow"}, 32'(o_sb_overflow), 0);
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         chk("write_en", 32'(o_write_en), 32'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            if (o_write_en) begin
               chk("write_add", 32'(o_write_add), 32'(mon_e.add));
               chk("write_data", 32'(o_write_data), 32'(mon_e.data));
               chk("forward", 32'(o_forward), 1);
               chk("forward_add", 32'(o_forward_add), 32'(mon_e.add));
            end
         end
      end
   end

   initial begin
      model_reset();
      #1;
      check_all_zero("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      mon_on = 1'b1;

      // single ALU write r3
      cyc(1, 3, 'h1234, 0, 0, 0, 0, 0, 0, 0);
      idle(3);
      // same-register race: load must land first
      cyc(1, 5, 'hAAAA, 1, 5, 'h5555, 0, 0, 0, 0);
      idle(4);
      // both streams saturated, different registers
      for (int i = 0; i < 12; i++) cyc(1, 1, $urandom, 1, 9, $urandom, 0, 0, 0, 0);
      idle(4);
      // pending-write stall on r7
      cyc(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
      idle(1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
      cyc(1, 7, 'h0707, 0, 0, 0, 0, 0, 7, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
      // reserve and release r2 in the same cycle
      cyc(0, 0, 0, 0, 0, 0, 1, 2, 2, 0);
      cyc(1, 2, 'h2222, 0, 0, 0, 0, 0, 0, 2);
      cyc(0, 0, 0, 0, 0, 0, 1, 2, 2, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 2, 2);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
      // saturate r7 until overflow
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
      idle(2);

      for (int i = 0; i < 400; i++) begin
         int amax;
         amax = ($urandom_range(0, 1) == 0) ? 3 : 15;
         cyc($urandom_range(0, 99) < 60, $urandom_range(0, amax), $urandom,
             $urandom_range(0, 99) < 60, $urandom_range(0, amax), $urandom,
             $urandom_range(0, 99) < 15, $urandom_range(0, 15),
             $urandom_range(0, 15), $urandom_range(0, 15));
      end

      // reset with two entries buffered
      cyc(1, 4, 'h4444, 1, 6, 'h6666, 0, 0, 0, 0);
      @(negedge clk);
      #2;
      reset = 1'b0;
      mon_on = 1'b0;
      i_alu_valid = 0; i_ld_valid = 0; i_reserve_en = 0;
      i_read_add1 = 4'd7; i_read_add2 = 4'd2;
      model_reset();
      #1;
      check_all_zero("midreset");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      mon_on = 1'b1;
      idle(3);
      for (int i = 0; i < 100; i++)
         cyc($urandom_range(0, 1), $urandom_range(0, 3), $urandom,
             $urandom_range(0, 1), $urandom_range(0, 3), $urandom,
             $urandom_range(0, 99) < 10, $urandom_range(0, 15),
             $urandom_range(0, 15), $urandom_range(0, 15));
      idle(6);
      @(negedge clk);
      mon_on = 1'b0;
      chk("drain", 32'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-back scheduler for the 16 x 16-bit register file. It merges the ALU and load-unit result streams onto the file's single write port, keeping same-register writes in program order. It runs a per-register pending-write scoreboard that drives the decode stall, and it generates the `forward`/`forward_add` hints the register file consumes. It sits between execute/memory stages and the register file's write and forward inputs.

## Interface
- `DATA_W`, 16, register data width
- `ADDR_W`, 4, register address width (16 registers)
- `FIFO_DEPTH`, 2, entries per requester buffer (fixed at 2; other values unsupported)

- `clk`  in  1  single clock; all state on posedge
- `reset`  in  1  asynchronous, active-low reset
- `i_alu_valid`  in  1  ALU result offered
- `o_alu_ready`  out  1  ALU buffer can accept
- `i_alu_add`  in  4  ALU destination register
- `i_alu_data`  in  16  ALU result
- `i_ld_valid`, `o_ld_ready`, `i_ld_add` (4), `i_ld_data` (16)  same meaning, load unit
- `i_reserve_en`  in  1  decode reserves a destination
- `i_reserve_add`  in  4  reserved register
- `i_read_add1`, `i_read_add2`  in  4  decode source registers
- `o_stall`  out  1  a source has a pending write
- `o_write_en`, `o_write_add` (4), `o_write_data` (16)  out  registered write port to register file
- `o_forward`  out  1  a write is being presented this cycle
- `o_forward_add`  out  4  register being written
- `o_sb_overflow`  out  1  sticky scoreboard-overflow flag

## Operation
- Reset values: all outputs 0. Readies read 1 after reset release. FIFOs empty, all scoreboard counts 0, round-robin pointer = ALU, stamp counter 0.
- Enqueue: a requester's entry is accepted when valid & ready at posedge. Each entry stores add, data and a 3-bit arrival stamp.
  - The stamp counter advances by the number accepted that cycle.
  - On simultaneous accept, load takes the lower (older) stamp.
- Ready: `o_x_ready` = FIFO not full, from registered occupancy only. A full FIFO dequeuing this cycle still shows ready=0.
- Arbitration, each cycle with at least one non-empty head:
  - One head only: that head is granted.
  - Both heads, same address: the older stamp wins. B is older-than-A iff (A−B) mod 8 ∈ {1,2,3}.
  - Both heads, different addresses: round-robin. The requester not granted last wins.
  - The pointer updates on every grant.
- Grant: at posedge, the winning head is popped and the outputs are loaded.
  - `o_write_en`=1, `o_write_add`/`o_write_data` = entry.
  - `o_forward`=1, `o_forward_add` = entry add.
  - With no grant, `o_write_en`/`o_forward` = 0 and add/data hold their last value.
- Scoreboard: a 2-bit count per register.
  - Reserve increments; grant decrements. Both on the same register in the same cycle leave it unchanged.
  - Reserve at 3: the count holds and `o_sb_overflow` sets, staying set until reset.
  - Grant at 0 (unreserved write): the count stays 0; this is not an error.
- `o_stall` is combinational: count[`i_read_add1`]≠0 or count[`i_read_add2`]≠0. It is forced 0 during reset.

## Timing
- Uncontested latency: accept at edge N → `o_write_en` high for the cycle after edge N+1. The register file commits at the following negedge.
- Throughput: one write per cycle. A contested requester waits at least one cycle.
- The scoreboard decrement takes effect at the grant edge. `o_stall` for that register drops in the same cycle that `o_write_en` rises.
- Reserve at edge N → `o_stall` visible after edge N.
- Reset mid-operation: asynchronous clear of everything. Buffered entries are discarded. Outputs are 0 immediately.
- Stamp wraps modulo 8. At most 4 entries are live, so the age compare is always unambiguous.

## Structure
- Shared package `cpu_pkg`: `DATA_W`, `ADDR_W`, `NUM_REGS`=16, requester enum `REQ_ALU`=0/`REQ_LD`=1, and the write-back entry struct (add, data, stamp).
- Sub-module `wb_fifo`: 2-entry FIFO with push, pop, head, full and empty. It is instantiated once per requester.
- Arbiter, stamp counter, scoreboard and output registers live in the top.

## Test plan
- Single ALU write, r3=0x1234 → `o_write_en`=1, `o_write_add`=3, data 0x1234, two cycles after valid edge; `o_forward_add`=3.
- ALU r5=0xAAAA and load r5=0x5555 accepted same edge → load granted first, then ALU. Final write order: 0x5555, 0xAAAA.
- Both FIFOs kept full, with different addresses → grants alternate ALU/LD every cycle; readies toggle correctly; no entry lost or duplicated.
- Reserve r7, then `i_read_add1`=7 → `o_stall`=1 until the r7 grant cycle, then 0. Reserve r7 four times → `o_sb_overflow`=1.
- Reserve and grant r2 in the same cycle with count 1 → count stays 1 and `o_stall` remains 1 for reads of r2.
- Assert `reset`=0 with two entries buffered → all outputs 0 immediately. After release, no stale write appears and readies are 1.
